fifo_stream_reader: RTL

//  Read-side drain stage directly downstream of the synchronous FIFO.
//  - Issues rd_en to the FIFO and absorbs the FIFO's 1-cycle registered read latency.
//  - Presents the words on a valid/ready stream at full throughput (1 word/cycle).
//  - Has no combinational path from m_ready to fifo_rd_en.
//  - Sits between the FIFO output and any consumer that can apply backpressure.

---
 rtl/fifo_stream_reader_pkg.sv | 18 +
 rtl/fifo_stream_reader_skid_buf.sv | 48 ++++
 rtl/fifo_stream_reader.sv | 69 ++++++
 3 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants, types and helpers for the FIFO read-side stream stage.
package fifo_stream_reader_pkg;

  localparam int unsigned FIFO_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned SKID_DEPTH = 3;
  localparam int unsigned OCC_W      = 2;
  localparam int unsigned FILL_W     = 3;

  typedef logic [FIFO_WIDTH-1:0] data_t;
  typedef logic [OCC_W-1:0]      occ_t;

  // Advance a skid-buffer pointer, wrapping after the last entry.
  function automatic occ_t ptr_inc(input occ_t p);
    return (p == occ_t'(SKID_DEPTH - 1)) ? occ_t'(0) : p + occ_t'(1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Three-entry circular skid buffer that absorbs words already requested from the FIFO.
module fifo_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output occ_t             occ
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  occ_t             rptr;
  occ_t             wptr;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   occ <= occ + occ_t'(1);
        2'b01:   occ <= occ - occ_t'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage; contents are only meaningful where occ says so, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Head-of-buffer read, forced to zero when empty.
  always_comb begin
    dout = '0;
    if (occ != occ_t'(0)) dout = mem[rptr];
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream at one word per cycle,
// hiding the FIFO's one-cycle read latency behind a three-entry skid buffer.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = fifo_stream_reader_pkg::FIFO_WIDTH,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      xfer_count,
  output logic                  busy
);

  logic              inflight;
  occ_t              occ;
  logic              hs;
  logic [FILL_W-1:0] fill;

  assign hs   = m_valid && m_ready;
  // Slots already committed: buffered words plus the word on its way out of the FIFO.
  assign fill = FILL_W'(occ) + FILL_W'(inflight);

  // Read only while a slot is guaranteed for the returning word; m_ready is not involved.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!rst && !fifo_empty && (fill < FILL_W'(SKID_DEPTH))) fifo_rd_en = 1'b1;
  end

  // Tracks the FIFO's registered read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end

  // Completed-handshake counter, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     xfer_count <= '0;
    else if (hs) xfer_count <= xfer_count + CNT_W'(1);
  end

  fifo_skid_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (fifo_dout),
    .pop  (hs),
    .dout (m_data),
    .occ  (occ)
  );

  assign m_valid = (occ != occ_t'(0));
  assign busy    = inflight || m_valid;

  // Structural invariants of the drain stage.
  a_fill_bound : assert property (@(posedge clk) disable iff (rst) fill <= FILL_W'(SKID_DEPTH));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst) !(fifo_rd_en && fifo_empty));
  a_data_hold : assert property (@(posedge clk) disable iff (rst)
                                 (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule
